// File: rtl/axil_master_if.sv
// AXI4-Lite bus bundle (AW/W/B/AR/R channels) with master and slave views.
interface axil_if #(
  parameter int ADDR_WIDTH = 40,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one response record out.
// Optional AXIL_MASTER_ERR_CNT_EN adds saturating wr/rd/err transaction counters.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | cmd_ready high, waiting for a command
// WR_REQ  | AW and W valids pending, each drops on its own handshake
// WR_RESP | bready high, waiting for B
// RD_REQ  | arvalid pending
// RD_RESP | rready high, waiting for R
// RSP     | rsp_valid high, waiting for rsp_ready
module axil_master #(
  parameter int         ADDR_WIDTH = 40,
  parameter int         DATA_WIDTH = 32,
  parameter logic [2:0] AXI_PROT   = 3'b000
) (
  input  logic                    axi_aclk,
  input  logic                    axi_reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
`ifdef AXIL_MASTER_ERR_CNT_EN
  output logic [15:0]             wr_count,
  output logic [15:0]             rd_count,
  output logic [15:0]             err_count,
`endif
  axil_if.master                  m_axi
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic                    awvalid_q, awvalid_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]              rsp_resp_q, rsp_resp_d;
  logic                    rsp_enter;
  logic                    aw_hs, w_hs;

  assign aw_hs = awvalid_q & m_axi.awready;
  assign w_hs  = wvalid_q & m_axi.wready;

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      awaddr_q    <= '0;
      awvalid_q   <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awaddr_q    <= awaddr_d;
      awvalid_q   <= awvalid_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awaddr_d    = awaddr_q;
    awvalid_d   = awvalid_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_enter   = 1'b0;

    case (state_q)
      IDLE: begin
        // cmd_ready is registered, so it rises one cycle after entering IDLE
        cmd_ready_d = 1'b1;
        aw_done_d   = 1'b0;
        w_done_d    = 1'b0;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (m_axi.bvalid && bready_q) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = m_axi.bresp;
          rsp_enter   = 1'b1;
          state_d     = RSP;
        end
      end
      RD_REQ: begin
        if (arvalid_q && m_axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_RESP;
        end
      end
      RD_RESP: begin
        if (m_axi.rvalid && rready_q) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = m_axi.rdata;
          rsp_resp_d  = m_axi.rresp;
          rsp_enter   = 1'b1;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef AXIL_MASTER_ERR_CNT_EN
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      wr_count  <= 16'd0;
      rd_count  <= 16'd0;
      err_count <= 16'd0;
    end else if (rsp_enter) begin
      if (rsp_write_d && wr_count != 16'hFFFF)
        wr_count <= wr_count + 16'd1;
      if (!rsp_write_d && rd_count != 16'hFFFF)
        rd_count <= rd_count + 16'd1;
      if (rsp_resp_d != 2'b00 && err_count != 16'hFFFF)
        err_count <= err_count + 16'd1;
    end
  end
`endif

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_write     = rsp_write_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awprot  = AXI_PROT;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arprot  = AXI_PROT;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

endmodule

// File: tb/tb_axil_master.sv
// Directed bench for axil_master with a small 4-register AXI4-Lite slave model.
module tb_axil_master;

  logic        axi_aclk = 1'b0;
  logic        axi_reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [39:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
`ifdef AXIL_MASTER_ERR_CNT_EN
  logic [15:0] wr_count, rd_count, err_count;
`endif

  axil_if #(.ADDR_WIDTH(40), .DATA_WIDTH(32)) bus ();

  axil_master #(.ADDR_WIDTH(40), .DATA_WIDTH(32), .AXI_PROT(3'b000)) dut (
    .axi_aclk  (axi_aclk),
    .axi_reset (axi_reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
`ifdef AXIL_MASTER_ERR_CNT_EN
    .wr_count  (wr_count),
    .rd_count  (rd_count),
    .err_count (err_count),
`endif
    .m_axi     (bus)
  );

  always #5 axi_aclk = ~axi_aclk;

  // slave model: reg0=DEADBEEF, reg1=76543210 after reset; awready can be delayed
  logic [31:0] mem [4];
  logic        got_aw, got_w;
  logic [1:0]  aw_idx;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  int          aw_cnt;
  int          aw_delay = 0;
  bit          rd_err = 1'b0;
  int          b_cnt = 0;
  int          rsp_cnt = 0;

  wire         s_aw_hs = bus.awvalid && bus.awready;
  wire         s_w_hs  = bus.wvalid && bus.wready;
  wire  [1:0]  wr_idx  = s_aw_hs ? bus.awaddr[3:2] : aw_idx;
  wire  [31:0] wr_data = s_w_hs ? bus.wdata : w_data;
  wire  [3:0]  wr_strb = s_w_hs ? bus.wstrb : w_strb;

  assign bus.awready = bus.awvalid && (aw_cnt >= aw_delay);
  assign bus.wready  = bus.wvalid;
  assign bus.arready = bus.arvalid;

  always @(posedge axi_aclk) begin
    if (axi_reset) begin
      mem[0]     <= 32'hDEADBEEF;
      mem[1]     <= 32'h76543210;
      mem[2]     <= 32'h0;
      mem[3]     <= 32'h0;
      got_aw     <= 1'b0;
      got_w      <= 1'b0;
      aw_idx     <= 2'd0;
      w_data     <= 32'h0;
      w_strb     <= 4'h0;
      aw_cnt     <= 0;
      bus.bvalid <= 1'b0;
      bus.bresp  <= 2'b00;
      bus.rvalid <= 1'b0;
      bus.rdata  <= 32'h0;
      bus.rresp  <= 2'b00;
    end else begin
      aw_cnt <= (bus.awvalid && !bus.awready) ? aw_cnt + 1 : 0;
      if (s_aw_hs) begin
        got_aw <= 1'b1;
        aw_idx <= bus.awaddr[3:2];
      end
      if (s_w_hs) begin
        got_w  <= 1'b1;
        w_data <= bus.wdata;
        w_strb <= bus.wstrb;
      end
      if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
      if ((got_aw || s_aw_hs) && (got_w || s_w_hs)) begin
        for (int i = 0; i < 4; i++)
          if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        got_aw     <= 1'b0;
        got_w      <= 1'b0;
        bus.bvalid <= 1'b1;
        bus.bresp  <= 2'b00;
      end
      if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
      if (bus.arvalid && bus.arready) begin
        bus.rvalid <= 1'b1;
        bus.rdata  <= rd_err ? 32'hBAD0BAD0 : mem[bus.araddr[3:2]];
        bus.rresp  <= rd_err ? 2'b10 : 2'b00;
      end
    end
  end

  always @(posedge axi_aclk) begin
    if (bus.bvalid && bus.bready) b_cnt <= b_cnt + 1;
    if (rsp_valid && rsp_ready) rsp_cnt <= rsp_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("cmd_ready_wait", cmd_ready, 1);
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("rsp_valid_wait", rsp_valid, 1);
  endtask

  // returns just after the acceptance edge (cycle 1)
  task automatic issue(input logic w, input logic [39:0] a, input logic [31:0] d, input logic [3:0] s);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic collect(output logic [31:0] rd, output logic [1:0] rs, output logic wr);
    wait_rsp();
    rd = rsp_rdata;
    rs = rsp_resp;
    wr = rsp_write;
    tick();
  endtask

  logic [31:0] rd;
  logic [1:0]  rs;
  logic        wr;
  int          b0, r0;

  initial begin
    axi_reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_wstrb = '0;
    rsp_ready = 1'b1;
    repeat (3) tick();

    // reset state
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_awvalid", bus.awvalid, 0);
    chk("rst_wvalid", bus.wvalid, 0);
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_bready", bus.bready, 0);
    chk("rst_rready", bus.rready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_awaddr", bus.awaddr, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    axi_reset = 1'b0;
    tick();
    chk("post_rst_cmd_ready", cmd_ready, 1);

    // zero-wait write to reg2
    issue(1'b1, 40'h08, 32'h12345678, 4'hF);
    chk("wr_c1_cmd_ready", cmd_ready, 0);
    chk("wr_c1_awvalid", bus.awvalid, 1);
    chk("wr_c1_wvalid", bus.wvalid, 1);
    chk("wr_c1_awaddr", bus.awaddr, 40'h08);
    chk("wr_c1_wdata", bus.wdata, 32'h12345678);
    chk("wr_c1_wstrb", bus.wstrb, 4'hF);
    chk("wr_c1_awprot", bus.awprot, 3'b000);
    tick();
    chk("wr_c2_awvalid", bus.awvalid, 0);
    chk("wr_c2_wvalid", bus.wvalid, 0);
    chk("wr_c2_bready", bus.bready, 1);
    tick();
    chk("wr_c3_rsp_valid", rsp_valid, 1);
    chk("wr_c3_rsp_resp", rsp_resp, 2'b00);
    chk("wr_c3_rsp_rdata", rsp_rdata, 0);
    chk("wr_c3_rsp_write", rsp_write, 1);
    chk("wr_c3_bready", bus.bready, 0);
    tick();
    chk("wr_c4_rsp_valid", rsp_valid, 0);
    chk("wr_c4_cmd_ready", cmd_ready, 0);
    tick();
    chk("wr_c5_cmd_ready", cmd_ready, 1);

    // zero-wait read of reg0
    issue(1'b0, 40'h00, 32'h0, 4'h0);
    chk("rd_c1_arvalid", bus.arvalid, 1);
    chk("rd_c1_araddr", bus.araddr, 40'h00);
    chk("rd_c1_awvalid", bus.awvalid, 0);
    tick();
    chk("rd_c2_arvalid", bus.arvalid, 0);
    chk("rd_c2_rready", bus.rready, 1);
    tick();
    chk("rd_c3_rsp_valid", rsp_valid, 1);
    chk("rd_c3_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("rd_c3_rsp_resp", rsp_resp, 2'b00);
    chk("rd_c3_rsp_write", rsp_write, 0);
    chk("rd_c3_rready", bus.rready, 0);
    tick();

    issue(1'b0, 40'h04, 32'h0, 4'h0);
    collect(rd, rs, wr);
    chk("rd4_rdata", rd, 32'h76543210);
    chk("rd4_resp", rs, 2'b00);
    issue(1'b0, 40'h08, 32'h0, 4'h0);
    collect(rd, rs, wr);
    chk("rd8_readback", rd, 32'h12345678);

    // staggered write: awready three cycles late, wready immediate
    b0 = b_cnt;
    r0 = rsp_cnt;
    aw_delay = 3;
    issue(1'b1, 40'h0C, 32'hCAFEF00D, 4'hF);
    chk("stg_c1_awvalid", bus.awvalid, 1);
    chk("stg_c1_wvalid", bus.wvalid, 1);
    tick();
    chk("stg_c2_wvalid", bus.wvalid, 0);
    chk("stg_c2_awvalid", bus.awvalid, 1);
    tick();
    chk("stg_c3_awvalid", bus.awvalid, 1);
    chk("stg_c3_awaddr", bus.awaddr, 40'h0C);
    tick();
    chk("stg_c4_awvalid", bus.awvalid, 1);
    chk("stg_c4_bready", bus.bready, 0);
    tick();
    chk("stg_c5_awvalid", bus.awvalid, 0);
    chk("stg_c5_bready", bus.bready, 1);
    collect(rd, rs, wr);
    chk("stg_resp", rs, 2'b00);
    chk("stg_write", wr, 1);
    aw_delay = 0;
    repeat (3) tick();
    chk("stg_b_count", b_cnt - b0, 1);
    chk("stg_rsp_count", rsp_cnt - r0, 1);
    issue(1'b0, 40'h0C, 32'h0, 4'h0);
    collect(rd, rs, wr);
    chk("stg_readback", rd, 32'hCAFEF00D);

    // response backpressure with a second command pending
    rsp_ready = 1'b0;
    issue(1'b0, 40'h04, 32'h0, 4'h0);
    wait_rsp();
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 40'h00;
    for (int i = 0; i < 10; i++) begin
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_rdata", rsp_rdata, 32'h76543210);
      chk("bp_rsp_write", rsp_write, 0);
      chk("bp_cmd_ready", cmd_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_h1_rsp_valid", rsp_valid, 0);
    chk("bp_h1_cmd_ready", cmd_ready, 0);
    chk("bp_h1_arvalid", bus.arvalid, 0);
    tick();
    chk("bp_h2_cmd_ready", cmd_ready, 1);
    chk("bp_h2_arvalid", bus.arvalid, 0);
    tick();
    cmd_valid = 1'b0;
    chk("bp_h3_cmd_ready", cmd_ready, 0);
    chk("bp_h3_arvalid", bus.arvalid, 1);
    chk("bp_h3_araddr", bus.araddr, 40'h00);
    collect(rd, rs, wr);
    chk("bp_second_rdata", rd, 32'hDEADBEEF);

    // slave error passed through
    rd_err = 1'b1;
    issue(1'b0, 40'h04, 32'h0, 4'h0);
    collect(rd, rs, wr);
    rd_err = 1'b0;
    chk("err_resp", rs, 2'b10);
    chk("err_rdata", rd, 32'hBAD0BAD0);
    chk("err_write", wr, 0);
`ifdef AXIL_MASTER_ERR_CNT_EN
    chk("cnt_err", err_count, 1);
    chk("cnt_rd", rd_count, 7);
    chk("cnt_wr", wr_count, 2);
`endif

    // reset while awvalid is pending
    aw_delay = 5;
    issue(1'b1, 40'h00, 32'h11111111, 4'hF);
    tick();
    chk("mid_awvalid_pre", bus.awvalid, 1);
    axi_reset = 1'b1;
    tick();
    chk("mid_awvalid", bus.awvalid, 0);
    chk("mid_wvalid", bus.wvalid, 0);
    chk("mid_arvalid", bus.arvalid, 0);
    chk("mid_bready", bus.bready, 0);
    chk("mid_rready", bus.rready, 0);
    chk("mid_cmd_ready", cmd_ready, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
`ifdef AXIL_MASTER_ERR_CNT_EN
    chk("mid_cnt_wr", wr_count, 0);
    chk("mid_cnt_err", err_count, 0);
`endif
    axi_reset = 1'b0;
    aw_delay = 0;
    tick();
    chk("mid_post_cmd_ready", cmd_ready, 1);
    issue(1'b0, 40'h00, 32'h0, 4'h0);
    collect(rd, rs, wr);
    chk("mid_fresh_rdata", rd, 32'hDEADBEEF);
    chk("mid_fresh_resp", rs, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
